// File: rtl/rand_range_gen.sv
// Level-driven pseudo-random source: free-running Galois LFSR with per-level rejection
// sampling, a fold fallback after MAX_TRIES rejected draws, and a req/busy/valid handshake.
module rand_range_gen #(
    parameter int                WIDTH     = 10,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter int                MAX_TRIES = 8,
    parameter int                DEFAULT   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        level,
    input  logic              req,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic              busy,
    output logic              valid,
    output logic [WIDTH-1:0]  number,
    output logic              bad_level,
    output logic              folded
);

    localparam int SW    = 10;
    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    typedef enum logic {IDLE, DRAW} state_t;

    function automatic int tab_lo(input int lv);
        case (lv)
            7, 8:    return -128;
            9:       return -256;
            10:      return -512;
            default: return 0;
        endcase
    endfunction

    function automatic int tab_span(input int lv);
        case (lv)
            1: return 7;    2: return 15;   3: return 31;   4: return 63;   5: return 127;
            6: return 255;  7: return 383;  8: return 639;  9: return 767;  10: return 1023;
            default: return 0;
        endcase
    endfunction

    function automatic int tab_mask(input int lv);
        case (lv)
            7:           return 511;
            8, 9, 10:    return 1023;
            default:     return tab_span(lv);
        endcase
    endfunction

    logic [WIDTH-1:0] lo_tab   [16];
    logic [SW-1:0]    span_tab [16];
    logic [SW-1:0]    mask_tab [16];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_tab
            assign lo_tab[gi]   = WIDTH'(tab_lo(gi));
            assign span_tab[gi] = SW'(tab_span(gi));
            assign mask_tab[gi] = SW'(tab_mask(gi));
        end
    endgenerate

    state_t            state_reg, state_next;
    logic [LFSR_W-1:0] lfsr_reg, lfsr_next, lfsr_step;
    logic [3:0]        level_reg, level_next;
    logic [TRY_W-1:0]  try_cnt_reg, try_cnt_next;
    logic [WIDTH-1:0]  number_reg, number_next;
    logic              valid_reg, valid_next;
    logic              bad_reg, bad_next;
    logic              fold_reg, fold_next;

    logic [SW-1:0]     sample, offset;
    logic [WIDTH-1:0]  sum;
    logic              level_ok, hit, last_try, finish;

    always_comb begin
        lfsr_step = lfsr_reg >> 1;
        if (lfsr_reg[0])
            lfsr_step = lfsr_step ^ TAPS;
        lfsr_next = lfsr_step;
        if (seed_load)
            lfsr_next = (seed_in == '0) ? SEED : seed_in;
    end

    // Draw decision uses the LFSR value present at this edge; every result fits
    // in WIDTH bits, so the lo+offset sum needs no extra headroom bit.
    assign sample   = lfsr_reg[SW-1:0] & mask_tab[level_reg];
    assign level_ok = (level_reg != 4'd0) && (level_reg <= 4'd10);
    assign hit      = sample < span_tab[level_reg];
    assign last_try = try_cnt_reg == TRY_W'(MAX_TRIES - 1);
    assign finish   = (state_reg == DRAW) && (!level_ok || hit || last_try);
    assign offset   = hit ? sample : sample - span_tab[level_reg];
    assign sum      = lo_tab[level_reg] + WIDTH'(offset);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            lfsr_reg    <= SEED;
            level_reg   <= '0;
            try_cnt_reg <= '0;
            number_reg  <= WIDTH'(DEFAULT);
            valid_reg   <= 1'b0;
            bad_reg     <= 1'b0;
            fold_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lfsr_reg    <= lfsr_next;
            level_reg   <= level_next;
            try_cnt_reg <= try_cnt_next;
            number_reg  <= number_next;
            valid_reg   <= valid_next;
            bad_reg     <= bad_next;
            fold_reg    <= fold_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req) state_next = DRAW;
            DRAW:    if (finish) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        level_next   = level_reg;
        try_cnt_next = try_cnt_reg;
        number_next  = number_reg;
        valid_next   = finish;
        bad_next     = finish && !level_ok;
        fold_next    = finish && level_ok && !hit;
        if (state_reg == IDLE && req) begin
            level_next   = level;
            try_cnt_next = '0;
        end else if (state_reg == DRAW && !finish) begin
            try_cnt_next = try_cnt_reg + 1'b1;
        end
        if (finish)
            number_next = level_ok ? sum : WIDTH'(DEFAULT);
    end

    assign busy      = (state_reg == DRAW);
    assign valid     = valid_reg;
    assign number    = number_reg;
    assign bad_level = bad_reg;
    assign folded    = fold_reg;

endmodule

// File: tb/tb_rand_range_gen.sv
// Bench for rand_range_gen: a reference LFSR plus a per-request draw model built from
// the level range table; instance a uses MAX_TRIES=8, instance b uses MAX_TRIES=1.
module tb_rand_range_gen;

    localparam logic [15:0] TAPS = 16'hB400;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset = 1'b0, seed_load = 1'b0;
    logic [15:0] seed_in = '0;
    logic [3:0]  level_a = '0, level_b = '0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic        busy_a, valid_a, bad_a, fold_a;
    logic        busy_b, valid_b, bad_b, fold_b;
    logic [9:0]  number_a, number_b;

    int checks = 0;
    int failures = 0;
    int last_num = 0;

    int lo_t   [0:10] = '{0, 0, 0, 0, 0, 0, 0, -128, -128, -256, -512};
    int span_t [0:10] = '{0, 7, 15, 31, 63, 127, 255, 383, 639, 767, 1023};
    int mask_t [0:10] = '{0, 7, 15, 31, 63, 127, 255, 511, 1023, 1023, 1023};

    logic [15:0] model_lfsr;
    logic [15:0] samp_q[$];

    always #5 clk = ~clk;

    rand_range_gen #(.MAX_TRIES(8)) dut_a (
        .clk(clk), .reset(reset), .level(level_a), .req(req_a),
        .seed_load(seed_load), .seed_in(seed_in), .busy(busy_a), .valid(valid_a),
        .number(number_a), .bad_level(bad_a), .folded(fold_a)
    );

    rand_range_gen #(.MAX_TRIES(1)) dut_b (
        .clk(clk), .reset(reset), .level(level_b), .req(req_b),
        .seed_load(seed_load), .seed_in(seed_in), .busy(busy_b), .valid(valid_b),
        .number(number_b), .bad_level(bad_b), .folded(fold_b)
    );

    function automatic logic [15:0] step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    endfunction

    always @(posedge clk) begin
        if (reset)          model_lfsr <= SEED;
        else if (seed_load) model_lfsr <= (seed_in == 16'd0) ? SEED : seed_in;
        else                model_lfsr <= step(model_lfsr);
    end

    // Walk the recorded per-edge LFSR values: the first draw that lands in range wins,
    // otherwise the last allowed draw is folded back by one span.
    function automatic void evaluate(input int lvl, input int maxt, output int lat,
                                     output int num, output bit bad, output bit fold);
        int s;
        bad = 0; fold = 0; lat = -1; num = 5;
        if (lvl < 1 || lvl > 10) begin
            bad = 1; lat = 1;
            return;
        end
        for (int i = 0; i < samp_q.size() && i < maxt; i++) begin
            s = int'(samp_q[i]) & mask_t[lvl];
            if (s < span_t[lvl]) begin
                lat = i + 1; num = lo_t[lvl] + s;
                return;
            end
            if (i == maxt - 1) begin
                lat = i + 1; num = lo_t[lvl] + s - span_t[lvl]; fold = 1;
                return;
            end
        end
    endfunction

    task automatic start_req(input bit use_b, input int lvl);
        if (use_b) begin level_b = 4'(lvl); req_b = 1'b1; end
        else       begin level_a = 4'(lvl); req_a = 1'b1; end
        @(posedge clk); @(negedge clk);
        req_a = 1'b0; req_b = 1'b0; seed_load = 1'b0;
    endtask

    task automatic wait_result(input bit use_b, input int lvl, input int maxt,
                               input bit hold_req, input string tag);
        int lat, num, got;
        bit bad, fold, seen, g_bad, g_fold, g_busy;
        samp_q.delete();
        seen = 0;
        checks++;
        g_busy = use_b ? busy_b : busy_a;
        if (g_busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_after_accept got=%b want=1", tag, g_busy);
        end
        for (int n = 0; n < 20; n++) begin
            samp_q.push_back(model_lfsr);
            @(posedge clk); @(negedge clk);
            seed_load = 1'b0;
            if (!hold_req) begin req_a = 1'b0; req_b = 1'b0; end
            if ((use_b ? valid_b : valid_a) === 1'b1) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s valid_timeout got=no_valid want=valid within 20 cycles", tag);
            return;
        end
        got    = int'($signed(use_b ? number_b : number_a));
        g_bad  = use_b ? bad_b : bad_a;
        g_fold = use_b ? fold_b : fold_a;
        g_busy = use_b ? busy_b : busy_a;
        last_num = got;
        evaluate(lvl, maxt, lat, num, bad, fold);
        checks += 5;
        if (samp_q.size() != lat) begin
            failures++;
            $display("FAIL %s latency got=%0d want=%0d", tag, samp_q.size(), lat);
        end
        if (got != num) begin
            failures++;
            $display("FAIL %s number got=%0d want=%0d", tag, got, num);
        end
        if (g_bad !== bad) begin
            failures++;
            $display("FAIL %s bad_level got=%b want=%b", tag, g_bad, bad);
        end
        if (g_fold !== fold) begin
            failures++;
            $display("FAIL %s folded got=%b want=%b", tag, g_fold, fold);
        end
        if (g_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_with_valid got=%b want=0", tag, g_busy);
        end
        $display("txn %s dut=%s level=%0d cycles=%0d number=%0d bad=%0b folded=%0b",
                 tag, use_b ? "b" : "a", lvl, samp_q.size(), got, g_bad, g_fold);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (number_a !== 10'd5) begin failures++; $display("FAIL reset number got=%0d want=5", number_a); end
        if (number_b !== 10'd5) begin failures++; $display("FAIL reset number_b got=%0d want=5", number_b); end
        if (valid_a !== 1'b0) begin failures++; $display("FAIL reset valid got=%b want=0", valid_a); end
        if (busy_a !== 1'b0) begin failures++; $display("FAIL reset busy got=%b want=0", busy_a); end
        if (bad_a !== 1'b0) begin failures++; $display("FAIL reset bad_level got=%b want=0", bad_a); end
        if (fold_a !== 1'b0) begin failures++; $display("FAIL reset folded got=%b want=0", fold_a); end
        $display("txn reset number=%0d valid=%b busy=%b", number_a, valid_a, busy_a);
        reset = 1'b0;
    endtask

    task automatic test_level1_seed();
        seed_load = 1'b1; seed_in = 16'h0001;
        @(posedge clk); @(negedge clk);
        seed_load = 1'b0;
        start_req(0, 1);
        wait_result(0, 1, 8, 0, "level1_seed");
        @(negedge clk);
        checks++;
        if (valid_a !== 1'b0) begin
            failures++;
            $display("FAIL valid_pulse_width got=%b want=0", valid_a);
        end
        checks++;
        if (last_num < 0 || last_num > 6) begin
            failures++;
            $display("FAIL level1_range got=%0d want=0..6", last_num);
        end
    endtask

    task automatic test_seed_zero();
        seed_load = 1'b1; seed_in = 16'h0000;
        start_req(0, 6);
        wait_result(0, 6, 8, 0, "seed_zero");
    endtask

    task automatic test_random_levels();
        int lvl;
        bit ub;
        for (int i = 0; i < 40; i++) begin
            lvl = $urandom_range(0, 12);
            ub  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) begin
                seed_load = 1'b1;
                seed_in = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            end
            start_req(ub, lvl);
            wait_result(ub, lvl, ub ? 1 : 8, 0, "random");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        level_a = 4'd10; req_a = 1'b1;
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < 2000; i++) begin
            wait_result(0, 10, 8, 1, "back_to_back");
            checks++;
            if (last_num < -512 || last_num > 510) begin
                failures++;
                $display("FAIL b2b_range got=%0d want=-512..510", last_num);
            end
            if (i == 1999) req_a = 1'b0;
            else begin @(posedge clk); @(negedge clk); end
        end
        @(negedge clk);
    endtask

    task automatic test_bad_level();
        start_req(0, 0);
        wait_result(0, 0, 8, 0, "bad_level0");
        start_req(0, 11);
        wait_result(0, 11, 8, 0, "bad_level11");
        start_req(0, $urandom_range(12, 15));
        wait_result(0, int'(level_a), 8, 0, "bad_level_hi");
    endtask

    task automatic test_fold();
        seed_load = 1'b1; seed_in = 16'd450;
        start_req(1, 7);
        wait_result(1, 7, 1, 0, "fold");
        checks += 2;
        if (last_num != -61) begin
            failures++;
            $display("FAIL fold_value got=%0d want=-61", last_num);
        end
        if (number_b !== 10'h3C3) begin
            failures++;
            $display("FAIL fold_raw got=%h want=3c3", number_b);
        end
    endtask

    task automatic test_seed_during_draw();
        seed_load = 1'b1; seed_in = 16'h0007;
        start_req(0, 1);
        seed_load = 1'b1; seed_in = 16'($urandom_range(1, 65535));
        wait_result(0, 1, 8, 0, "seed_mid_draw");
    endtask

    task automatic test_req_while_busy();
        int extra;
        seed_load = 1'b1; seed_in = 16'h0007;
        start_req(0, 1);
        level_a = 4'd3; req_a = 1'b1;
        wait_result(0, 1, 8, 0, "req_while_busy");
        extra = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (valid_a === 1'b1 || busy_a === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL req_while_busy_extra got=%0d want=0", extra);
        end
    endtask

    task automatic test_reset_mid_draw();
        int seen;
        seed_load = 1'b1; seed_in = 16'h03FF;
        start_req(0, 8);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            if (valid_a === 1'b1) seen++;
            @(negedge clk);
        end
        checks += 3;
        if (seen != 0) begin failures++; $display("FAIL reset_mid_draw valid got=%0d want=0", seen); end
        if (number_a !== 10'd5) begin failures++; $display("FAIL reset_mid_draw number got=%0d want=5", number_a); end
        if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_mid_draw busy got=%b want=0", busy_a); end
        $display("txn reset_mid_draw number=%0d valids=%0d", number_a, seen);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_level1_seed();
        test_seed_zero();
        test_bad_level();
        test_fold();
        test_seed_during_draw();
        test_req_while_busy();
        test_random_levels();
        test_back_to_back();
        test_reset_mid_draw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
